// File: rtl/wb_uart_fifo.sv
// Wishbone-attached 8N1 UART with RX/TX byte FIFOs.
// Registers: DATA, STATUS, DIVISOR and a reserved zero register.
module wb_uart_fifo #(
  parameter int DEFAULT_DIVISOR = 8,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int AW = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
  } rx_state_t;

  logic acc, data_wr, data_rd, stat_wr, div_wr;
  logic unused_dat;
  logic [15:0] divisor;
  logic ovr, fe, txo;
  logic [31:0] rdata;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [AW:0]   tx_cnt;
  logic tx_empty, tx_full, tx_push, tx_pop;

  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [AW:0]   rx_cnt;
  logic rx_empty, rx_full, rx_push, rx_pop;

  tx_state_t tx_q, tx_d;
  logic [15:0] tx_tick, tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic tx_end, tx_idle;

  rx_state_t rx_q, rx_d;
  logic rx_s1, rx_s2, rx_prev;
  logic [15:0] rx_tick, rx_div;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic rx_mid, rx_end, rx_start, rx_done, fe_set;

  assign acc     = wb_cyc_i & wb_stb_i;
  assign data_wr = acc & wb_we_i & (wb_adr_i == 2'd0);
  assign data_rd = acc & ~wb_we_i & (wb_adr_i == 2'd0);
  assign stat_wr = acc & wb_we_i & (wb_adr_i == 2'd1);
  assign div_wr  = acc & wb_we_i & (wb_adr_i == 2'd2);
  assign unused_dat = ^wb_dat_i[31:16];
  assign wb_stall_o = 1'b0;

  // ---------------- TX FIFO
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_push  = data_wr & (~tx_full | tx_pop);

  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem[tx_wp] <= wb_dat_i[7:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // ---------------- RX FIFO
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_pop   = data_rd & ~rx_empty;
  assign rx_push  = rx_done & (~rx_full | rx_pop);

  always_ff @(posedge wb_clk_i) begin
    if (rx_push) rx_mem[rx_wp] <= rx_sh;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // ---------------- TX FSM
  assign tx_end  = (tx_tick == tx_div - 16'd1);
  assign tx_idle = tx_empty & (tx_q == TX_IDLE);

  always_comb begin
    tx_d    = tx_q;
    tx_pop  = 1'b0;
    uart_tx = 1'b1;
    unique case (tx_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop = 1'b1;
          tx_d   = TX_START;
        end
      end
      TX_START: begin
        uart_tx = 1'b0;
        if (tx_end) tx_d = TX_DATA;
      end
      TX_DATA: begin
        uart_tx = tx_sh[0];
        if (tx_end && tx_bit == 3'd7) tx_d = TX_STOP;
      end
      TX_STOP: begin
        if (tx_end) begin
          tx_pop = ~tx_empty;
          tx_d   = tx_empty ? TX_IDLE : TX_START;
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_q    <= TX_IDLE;
      tx_tick <= '0;
      tx_div  <= 16'(DEFAULT_DIVISOR);
      tx_bit  <= '0;
      tx_sh   <= '0;
    end else begin
      tx_q <= tx_d;
      if (tx_pop) begin
        tx_sh   <= tx_mem[tx_rp];
        tx_div  <= divisor;
        tx_tick <= '0;
        tx_bit  <= '0;
      end else if (tx_q != TX_IDLE) begin
        if (tx_end) begin
          tx_tick <= '0;
          if (tx_q == TX_DATA) begin
            tx_sh  <= tx_sh >> 1;
            tx_bit <= tx_bit + 3'd1;
          end
        end else begin
          tx_tick <= tx_tick + 16'd1;
        end
      end
    end
  end

  // ---------------- RX FSM
  assign rx_mid = (rx_tick == (rx_div >> 1) - 16'd1);
  assign rx_end = (rx_tick == rx_div - 16'd1);

  always_comb begin
    rx_d     = rx_q;
    rx_start = 1'b0;
    rx_done  = 1'b0;
    fe_set   = 1'b0;
    unique case (rx_q)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_start = 1'b1;
          rx_d     = RX_START;
        end
      end
      RX_START: begin
        if (rx_mid) rx_d = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_end && rx_bit == 3'd7) rx_d = RX_STOP;
      end
      RX_STOP: begin
        if (rx_end) begin
          rx_done = rx_s2;
          fe_set  = ~rx_s2;
          rx_d    = rx_s2 ? RX_IDLE : RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (rx_s2) rx_d = RX_IDLE;
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_q    <= RX_IDLE;
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_tick <= '0;
      rx_div  <= 16'(DEFAULT_DIVISOR);
      rx_bit  <= '0;
      rx_sh   <= '0;
    end else begin
      rx_q    <= rx_d;
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (rx_start) begin
        rx_div  <= divisor;
        rx_tick <= '0;
      end else if (rx_q == RX_START && rx_mid) begin
        rx_tick <= '0;
        rx_bit  <= '0;
      end else if ((rx_q == RX_DATA || rx_q == RX_STOP) && rx_end) begin
        rx_tick <= '0;
        if (rx_q == RX_DATA) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
        end
      end else begin
        rx_tick <= rx_tick + 16'd1;
      end
    end
  end

  // ---------------- registers and bus
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      divisor <= 16'(DEFAULT_DIVISOR);
      ovr     <= 1'b0;
      fe      <= 1'b0;
      txo     <= 1'b0;
    end else begin
      if (div_wr)
        divisor <= (wb_dat_i[15:0] < 16'd4) ? 16'd4 : wb_dat_i[15:0];
      // a new event wins over a clear in the same cycle
      if (rx_done && rx_full && !rx_pop) ovr <= 1'b1;
      else if (stat_wr && wb_dat_i[3])   ovr <= 1'b0;
      if (fe_set)                      fe <= 1'b1;
      else if (stat_wr && wb_dat_i[4]) fe <= 1'b0;
      if (data_wr && tx_full && !tx_pop) txo <= 1'b1;
      else if (stat_wr && wb_dat_i[5])   txo <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (wb_adr_i)
      2'd0: if (!rx_empty) rdata[7:0] = rx_mem[rx_rp];
      2'd1: rdata[5:0] = {txo, fe, ovr, tx_idle, tx_full, ~rx_empty};
      2'd2: rdata[15:0] = divisor;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= (acc && !wb_we_i) ? rdata : '0;
    end
  end

endmodule
